// File: rtl/branch_pred_ctrl.sv
// branch_pred_ctrl
// Sequencing controller for the 2-bit branch history table.
// Keeps predicted branches in an in-order queue between IF and EX.
// Issues one table update per resolved branch.
// Raises a one-cycle flush with a redirect PC on a misprediction.
// Optional feature macro: BPC_STATS_EN adds saturating branch/mispredict counters.

module branch_pred_ctrl #(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alloc_valid,
   input  logic [31:0]      alloc_pc,
   input  logic             alloc_pred_taken,
   output logic             alloc_ready,
   output logic [PTR_W-1:0] alloc_tag,
   input  logic             res_valid,
   input  logic             res_taken,
   input  logic [31:0]      res_target,
   output logic [31:0]      bht_update_pc,
   output logic             bht_is_taken,
   output logic             bht_is_branch,
   output logic             flush,
   output logic [31:0]      redirect_pc,
   output logic [PTR_W:0]   count
`ifdef BPC_STATS_EN
   ,
   output logic [31:0]      stat_branches,
   output logic [31:0]      stat_mispredicts
`endif
);

   typedef enum logic {
      RUN     = 1'b0,
      RECOVER = 1'b1
   } state_t;

   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   state_t           state;
   state_t           state_next;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [31:0]      pc_q   [DEPTH];
   logic             pred_q [DEPTH];

   logic             do_alloc;
   logic             do_res;
   logic             mispredict;

   assign alloc_ready = (state == RUN) && (count < CNT_FULL);
   assign alloc_tag   = tail;
   assign do_alloc    = alloc_valid && alloc_ready;
   assign do_res      = res_valid && (count != '0);
   assign mispredict  = do_res && (res_taken != pred_q[head]);

   // State register: RUN normally, a single RECOVER bubble after each flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   // Next state: a mispredict enters RECOVER, which always falls back to RUN.
   always_comb begin
      state_next = state;
      case (state)
         RUN:     if (mispredict) state_next = RECOVER;
         RECOVER: state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   // Queue storage is written at the tail; contents need no reset.
   always_ff @(posedge clk) begin
      if (do_alloc) begin
         pc_q[tail]   <= alloc_pc;
         pred_q[tail] <= alloc_pred_taken;
      end
   end

   // Pointers and occupancy; a mispredict discards every entry, including a same-cycle allocation.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (mispredict) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_res)   head <= head + PTR_ONE;
         if (do_alloc) tail <= tail + PTR_ONE;
         case ({do_alloc, do_res})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Registered table update strobe and flush; redirect_pc holds until the next flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bht_update_pc <= '0;
         bht_is_taken  <= 1'b0;
         bht_is_branch <= 1'b0;
         flush         <= 1'b0;
         redirect_pc   <= '0;
      end else begin
         bht_is_branch <= do_res;
         bht_is_taken  <= do_res && res_taken;
         flush         <= mispredict;
         if (do_res) bht_update_pc <= pc_q[head];
         if (mispredict) redirect_pc <= res_taken ? res_target : (pc_q[head] + 32'd4);
      end
   end

`ifdef BPC_STATS_EN
   // Saturating counters of resolved branches and flushes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (do_res && (stat_branches != 32'hFFFF_FFFF))
            stat_branches <= stat_branches + 32'd1;
         if (mispredict && (stat_mispredicts != 32'hFFFF_FFFF))
            stat_mispredicts <= stat_mispredicts + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// tb_branch_pred_ctrl
// Directed testbench for branch_pred_ctrl with hand-computed expectations.
// Define BPC_STATS_EN on both files to also check the statistics counters.

module tb_branch_pred_ctrl;

   localparam int DEPTH = 4;
   localparam int PTR_W = 2;

   logic             clk;
   logic             rst;
   logic             alloc_valid;
   logic [31:0]      alloc_pc;
   logic             alloc_pred_taken;
   logic             alloc_ready;
   logic [PTR_W-1:0] alloc_tag;
   logic             res_valid;
   logic             res_taken;
   logic [31:0]      res_target;
   logic [31:0]      bht_update_pc;
   logic             bht_is_taken;
   logic             bht_is_branch;
   logic             flush;
   logic [31:0]      redirect_pc;
   logic [PTR_W:0]   count;
`ifdef BPC_STATS_EN
   logic [31:0]      stat_branches;
   logic [31:0]      stat_mispredicts;
`endif

   int tests_run;
   int tests_failed;

   branch_pred_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk              (clk),
      .rst              (rst),
      .alloc_valid      (alloc_valid),
      .alloc_pc         (alloc_pc),
      .alloc_pred_taken (alloc_pred_taken),
      .alloc_ready      (alloc_ready),
      .alloc_tag        (alloc_tag),
      .res_valid        (res_valid),
      .res_taken        (res_taken),
      .res_target       (res_target),
      .bht_update_pc    (bht_update_pc),
      .bht_is_taken     (bht_is_taken),
      .bht_is_branch    (bht_is_branch),
      .flush            (flush),
      .redirect_pc      (redirect_pc),
      .count            (count)
`ifdef BPC_STATS_EN
      ,
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
`endif
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, then advance past the next rising edge.
   task automatic applyStimulus(input logic av, input logic [31:0] apc, input logic apred,
                                input logic rv, input logic rtaken, input logic [31:0] rtgt);
      alloc_valid      = av;
      alloc_pc         = apc;
      alloc_pred_taken = apred;
      res_valid        = rv;
      res_taken        = rtaken;
      res_target       = rtgt;
      @(posedge clk);
      #1;
      alloc_valid = 1'b0;
      res_valid   = 1'b0;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   logic [31:0] fill_pc   [4];
   logic        fill_pred [4];

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      alloc_valid      = 1'b0;
      alloc_pc         = '0;
      alloc_pred_taken = 1'b0;
      res_valid        = 1'b0;
      res_taken        = 1'b0;
      res_target       = '0;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset values
      checkOutput("rst_ready",   32'(alloc_ready),   32'd1);
      checkOutput("rst_tag",     32'(alloc_tag),     32'd0);
      checkOutput("rst_count",   32'(count),         32'd0);
      checkOutput("rst_strobe",  32'(bht_is_branch), 32'd0);
      checkOutput("rst_taken",   32'(bht_is_taken),  32'd0);
      checkOutput("rst_upd_pc",  bht_update_pc,      32'd0);
      checkOutput("rst_flush",   32'(flush),         32'd0);
      checkOutput("rst_redir",   redirect_pc,        32'd0);
      rst = 1'b1;
      idle();
      idle();
      checkOutput("idle_ready",  32'(alloc_ready),   32'd1);
      checkOutput("idle_strobe", 32'(bht_is_branch), 32'd0);
      checkOutput("idle_flush",  32'(flush),         32'd0);

      // Correct prediction, single branch
      applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("s1_count",    32'(count),         32'd1);
      checkOutput("s1_tag",      32'(alloc_tag),     32'd1);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h500);
      checkOutput("s1_strobe",   32'(bht_is_branch), 32'd1);
      checkOutput("s1_upd_pc",   bht_update_pc,      32'h100);
      checkOutput("s1_taken",    32'(bht_is_taken),  32'd1);
      checkOutput("s1_flush",    32'(flush),         32'd0);
      checkOutput("s1_count0",   32'(count),         32'd0);
      idle();
      checkOutput("s1_strobe_1cyc", 32'(bht_is_branch), 32'd0);

      // Not-taken mispredict redirects to pc+4 and discards the younger branch
      applyStimulus(1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 32'h204, 1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("s2_count2",   32'(count),         32'd2);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h999);
      checkOutput("s2_flush",    32'(flush),         32'd1);
      checkOutput("s2_redir",    redirect_pc,        32'h204);
      checkOutput("s2_upd_pc",   bht_update_pc,      32'h200);
      checkOutput("s2_taken",    32'(bht_is_taken),  32'd0);
      checkOutput("s2_strobe",   32'(bht_is_branch), 32'd1);
      checkOutput("s2_count0",   32'(count),         32'd0);
      checkOutput("s2_ready0",   32'(alloc_ready),   32'd0);
      checkOutput("s2_tag0",     32'(alloc_tag),     32'd0);
      idle();
      checkOutput("s2_flush_1cyc", 32'(flush),       32'd0);
      checkOutput("s2_ready1",   32'(alloc_ready),   32'd1);
      checkOutput("s2_redir_hold", redirect_pc,      32'h204);

      // Taken mispredict with a same-cycle allocation that must be discarded
      applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("s3_count1",   32'(count),         32'd1);
      applyStimulus(1'b1, 32'h304, 1'b1, 1'b1, 1'b1, 32'h380);
      checkOutput("s3_flush",    32'(flush),         32'd1);
      checkOutput("s3_redir",    redirect_pc,        32'h380);
      checkOutput("s3_count0",   32'(count),         32'd0);
      checkOutput("s3_tag0",     32'(alloc_tag),     32'd0);
      applyStimulus(1'b1, 32'h308, 1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("s3_recover_drop", 32'(count),     32'd0);

      // Fill to DEPTH, drop a fifth allocation, then drain in order
      fill_pc[0] = 32'h400; fill_pred[0] = 1'b1;
      fill_pc[1] = 32'h404; fill_pred[1] = 1'b0;
      fill_pc[2] = 32'h408; fill_pred[2] = 1'b1;
      fill_pc[3] = 32'h40C; fill_pred[3] = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, fill_pc[i], fill_pred[i], 1'b0, 1'b0, 32'h0);
      checkOutput("s4_count4",   32'(count),         32'd4);
      checkOutput("s4_ready0",   32'(alloc_ready),   32'd0);
      checkOutput("s4_tag_wrap", 32'(alloc_tag),     32'd0);
      applyStimulus(1'b1, 32'h410, 1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("s4_drop",     32'(count),         32'd4);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, fill_pred[i], 32'h700);
         checkOutput($sformatf("s4_upd_pc%0d", i), bht_update_pc, fill_pc[i]);
         checkOutput($sformatf("s4_taken%0d", i), 32'(bht_is_taken), 32'(fill_pred[i]));
         checkOutput($sformatf("s4_strobe%0d", i), 32'(bht_is_branch), 32'd1);
         checkOutput($sformatf("s4_flush%0d", i), 32'(flush), 32'd0);
      end
      checkOutput("s4_count0",   32'(count),         32'd0);
      checkOutput("s4_tag0",     32'(alloc_tag),     32'd0);
      checkOutput("s4_ready1",   32'(alloc_ready),   32'd1);

      // Resolution against an empty queue is ignored
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h800);
      checkOutput("s5_strobe",   32'(bht_is_branch), 32'd0);
      checkOutput("s5_flush",    32'(flush),         32'd0);
      checkOutput("s5_count",    32'(count),         32'd0);
      checkOutput("s5_redir",    redirect_pc,        32'h380);

`ifdef BPC_STATS_EN
      checkOutput("stat_br",     stat_branches,      32'd7);
      checkOutput("stat_mp",     stat_mispredicts,   32'd2);
`endif

      // Asynchronous reset aborts a pending strobe and clears occupancy
      applyStimulus(1'b1, 32'h900, 1'b1, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 32'h904, 1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("s6_flush_pre", 32'(flush),        32'd1);
      checkOutput("s6_redir_pre", redirect_pc,       32'h904);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("s6_async_flush",  32'(flush),         32'd0);
      checkOutput("s6_async_strobe", 32'(bht_is_branch), 32'd0);
      checkOutput("s6_async_redir",  redirect_pc,        32'd0);
      checkOutput("s6_async_ready",  32'(alloc_ready),   32'd1);
      rst = 1'b1;
      applyStimulus(1'b1, 32'hA00, 1'b1, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 32'hA04, 1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("s6_count2",   32'(count),         32'd2);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("s6_async_count", 32'(count),      32'd0);
      checkOutput("s6_async_tag",   32'(alloc_tag),  32'd0);
      rst = 1'b1;
      idle();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/branch_pred_ctrl.md
# branch_pred_ctrl

Sequencing controller for the 2-bit branch history table in the 5-stage RV32I pipeline. Tracks every branch predicted in IF in an in-order queue until EX resolves it. Drives the table's update port with exactly one update per resolved branch, and raises a one-cycle flush with a redirect PC on misprediction. Sits between IF (allocation), EX (resolution) and the history table.

## Interface
- `DEPTH`, 4 — in-flight branch queue entries; power of two, ≥2
- `PTR_W`, $clog2(DEPTH) — pointer/tag width
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `alloc_valid`  in  1  IF presents a predicted branch this cycle
- `alloc_pc`  in  32  PC of that branch
- `alloc_pred_taken`  in  1  direction predicted by the history table
- `alloc_ready`  out  1  queue can accept an allocation this cycle
- `alloc_tag`  out  PTR_W  slot index given to the accepted branch (the current tail)
- `res_valid`  in  1  EX resolves the oldest outstanding branch
- `res_taken`  in  1  actual direction
- `res_target`  in  32  actual taken target
- `bht_update_pc`  out  32  PC for the table update port
- `bht_is_taken`  out  1  actual outcome for the table
- `bht_is_branch`  out  1  one-cycle update strobe
- `flush`  out  1  one-cycle mispredict flush to IF/ID
- `redirect_pc`  out  32  fetch PC to use when `flush` = 1
- `count`  out  PTR_W+1  occupied entries

## Operation
- Queue entry fields: `{pc[31:0], pred_taken}`. Head/tail pointers are PTR_W bits and wrap modulo DEPTH. Occupancy is held in `count`.
- FSM states:
  - RUN: normal operation.
  - RECOVER: one-cycle bubble after a flush. `alloc_ready` = 0. Always returns to RUN on the next cycle.
- `alloc_ready` = (state == RUN) && (count < DEPTH). It depends only on registered state, not on `res_valid` in the same cycle.
- Accepted allocation (`alloc_valid` && `alloc_ready`): writes the entry at tail, then tail+1. `alloc_valid` while not ready is dropped silently.
- Resolution with `res_valid` && count > 0 applies to the head entry:
  - Every resolution: next cycle `bht_update_pc` = head.pc, `bht_is_taken` = `res_taken`, `bht_is_branch` = 1. Head+1.
  - Mispredict when `res_taken` != head.pred_taken. Next cycle `flush` = 1 and `redirect_pc` = `res_taken` ? `res_target` : head.pc + 32'd4 (mod 2^32). Head, tail and count reset to 0 (all younger entries discarded). State goes to RECOVER.
  - Correct prediction: no flush.
- `res_valid` with count == 0 is ignored: no strobe, no flush.
- Simultaneous allocate and resolve, no mispredict: both take effect and count is unchanged. This is legal at count == DEPTH only if `alloc_ready` was already 1, which it cannot be at full, so the allocation is dropped.
- Simultaneous allocate and mispredict: the allocation is discarded (it is younger than the flushed head). Count becomes 0.

## Timing
- Reset values: `alloc_ready` = 1, `alloc_tag` = 0, `count` = 0, `bht_is_branch` = 0, `bht_is_taken` = 0, `bht_update_pc` = 0, `flush` = 0, `redirect_pc` = 0. State = RUN. Queue contents are don't-care.
- Reset asserted mid-operation clears all in-flight entries and aborts any pending strobe/flush immediately (asynchronously).
- `bht_is_*`, `flush`, `redirect_pc` are registered: one cycle of latency from `res_valid`. Each is high for exactly one cycle. `redirect_pc` holds its value until the next flush.
- The history table samples on the falling edge, so the strobe is consumed within its own high cycle.
- Mispredict at cycle N: `flush` at N+1, RECOVER at N+1 (`alloc_ready` = 0), allocation possible again at N+2.

## Configuration
- `BPC_STATS_EN`: when defined, adds outputs `stat_branches[31:0]` and `stat_mispredicts[31:0]`.
  - `stat_branches` increments once per accepted resolution; `stat_mispredicts` increments once per flush.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
  - When not defined, these ports and counters do not exist.

## Test plan
- Reset, then idle → `alloc_ready` = 1, `count` = 0, no strobe, no flush.
- Allocate PC 0x100 (pred 1), resolve `res_taken` = 1 → next cycle `bht_update_pc` = 0x100, `bht_is_taken` = 1, strobe 1 cycle, `flush` = 0, `count` = 0.
- Allocate 0x200 (pred 1) and 0x204; resolve `res_taken` = 0 → `flush` = 1, `redirect_pc` = 0x204, `count` = 0, `alloc_ready` = 0 for one cycle, then 1.
- Allocate 0x300 (pred 0); resolve taken with target 0x380 while `alloc_valid` is high → `redirect_pc` = 0x380, the allocation is discarded, `count` = 0.
- Fill to DEPTH = 4 → `alloc_ready` = 0, a 5th `alloc_valid` is dropped. Resolve 4 correctly → 4 strobes with PCs in allocation order, tail wraps, `alloc_tag` returns to 0.
- `res_valid` with an empty queue → no strobe. With `BPC_STATS_EN` defined: after the scenarios above, `stat_branches` = 7, `stat_mispredicts` = 2.
